// File: rtl/car_cmd_rx.sv
// car_cmd_rx: 8N1 UART receiver plus 3-byte (header, payload, checksum) command frame parser.
// Define CAR_CMD_RX_WATCHDOG_EN to build in the link watchdog that forces a stop when frames cease.
module car_cmd_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_in,
    output logic [3:0] move_cmd,
    output logic [3:0] speed_level,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       link_timeout
);
    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       STOP_CMD  = 4'b1000;

    if (CLKS_PER_BIT < 4 || TIMEOUT_CLKS < 2) begin : g_bad_params
        $error("car_cmd_rx: CLKS_PER_BIT must be >= 4 and TIMEOUT_CLKS >= 2");
    end

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CHECK} parse_state_e;

    logic sync1_q, rx_s_q, rx_prev_q;
    logic rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= uart_in;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_s = rx_s_q;

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_done_q, byte_done_d;
    logic             byte_err_q, byte_err_d;

    // Leaving STOP right after its mid-bit sample lets back-to-back start edges be caught.
    always_comb begin
        rx_state_d  = rx_state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = 1'b0;
        byte_err_d  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                    bit_cnt_d  = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d      = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d       = '0;
                    rx_state_d  = RX_IDLE;
                    byte_done_d = rx_s;
                    byte_err_d  = !rx_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q  <= RX_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            byte_err_q  <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            byte_err_q  <= byte_err_d;
        end
    end

    parse_state_e p_state_q, p_state_d;
    logic [7:0]   pay_q, pay_d;
    logic [3:0]   move_q, move_d;
    logic [3:0]   speed_q, speed_d;
    logic         cmd_valid_q, cmd_valid_d;
    logic         frame_err_q, frame_err_d;
    logic         wd_expired;

    // An accepted frame is evaluated after the watchdog force so it always wins.
    always_comb begin
        p_state_d   = p_state_q;
        pay_d       = pay_q;
        move_d      = move_q;
        speed_d     = speed_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        if (wd_expired) begin
            move_d  = STOP_CMD;
            speed_d = 4'h0;
        end
        if (byte_err_q) begin
            frame_err_d = 1'b1;
            p_state_d   = P_HUNT;
        end else if (byte_done_q) begin
            unique case (p_state_q)
                P_HUNT: begin
                    if (shift_q == HEADER) begin
                        p_state_d = P_PAYLOAD;
                    end
                end
                P_PAYLOAD: begin
                    pay_d     = shift_q;
                    p_state_d = P_CHECK;
                end
                P_CHECK: begin
                    p_state_d = P_HUNT;
                    if (shift_q == (HEADER ^ pay_q)) begin
                        cmd_valid_d = 1'b1;
                        move_d      = pay_q[3:0];
                        speed_d     = pay_q[7:4];
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: p_state_d = P_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q   <= P_HUNT;
            pay_q       <= '0;
            move_q      <= STOP_CMD;
            speed_q     <= 4'h0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            p_state_q   <= p_state_d;
            pay_q       <= pay_d;
            move_q      <= move_d;
            speed_q     <= speed_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef CAR_CMD_RX_WATCHDOG_EN
    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CLKS - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            link_timeout_q, link_timeout_d;

    assign wd_expired = (wd_cnt_q == WD_LAST);

    always_comb begin
        wd_cnt_d       = wd_cnt_q;
        link_timeout_d = link_timeout_q;
        if (cmd_valid_d) begin
            wd_cnt_d       = '0;
            link_timeout_d = 1'b0;
        end else if (wd_expired) begin
            link_timeout_d = 1'b1;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    // Comes out of reset expired: the car stays stopped until the first good frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q       <= '0;
            link_timeout_q <= 1'b1;
        end else begin
            wd_cnt_q       <= wd_cnt_d;
            link_timeout_q <= link_timeout_d;
        end
    end

    assign link_timeout = link_timeout_q;
`else
    assign wd_expired   = 1'b0;
    assign link_timeout = 1'b0;
`endif

    assign move_cmd    = move_q;
    assign speed_level = speed_q;
    assign cmd_valid   = cmd_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_car_cmd_rx.sv
// Testbench for car_cmd_rx: directed frames plus randomized byte traffic against a frame-level model.
// Follows CAR_CMD_RX_WATCHDOG_EN to decide whether the link watchdog is expected.
`timescale 1ns/1ps
module tb_car_cmd_rx;
    localparam int         CPB  = 16;
    localparam int         HALF = CPB / 2;
    localparam logic [7:0] HDR  = 8'hA5;
    localparam int         TMO  = 1000;
    localparam int         LAT  = 2 + HALF + 9 * CPB + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_in = 1'b1;
    logic [3:0] move_cmd, speed_level;
    logic       cmd_valid, frame_err, link_timeout;

    car_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .HEADER(HDR),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_in(uart_in),
        .move_cmd(move_cmd),
        .speed_level(speed_level),
        .cmd_valid(cmd_valid),
        .frame_err(frame_err),
        .link_timeout(link_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge away from the active edge.
    int   valid_seen = 0, err_seen = 0, both_seen = 0;
    int   last_valid_cyc = 0, lt_rise_cyc = -1;
    logic lt_prev = 1'b0;
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            valid_seen++;
            last_valid_cyc = cyc;
        end
        if (frame_err === 1'b1) err_seen++;
        if (cmd_valid === 1'b1 && frame_err === 1'b1) both_seen++;
        if (link_timeout === 1'b1 && lt_prev !== 1'b1) lt_rise_cyc = cyc;
        lt_prev = link_timeout;
    end

`ifdef CAR_CMD_RX_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    // Frame-level reference model: bytes collected positionally from a header.
    logic [7:0] rx_bytes[$];
    logic [3:0] exp_move = 4'b1000;
    logic [3:0] exp_speed = 4'h0;
    int         exp_valid = 0, exp_err = 0;
    int         last_exp_valid = -1000000;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int start);
        rx_bytes.push_back(b);
        if (rx_bytes[0] != HDR) begin
            rx_bytes.delete();
        end else if (rx_bytes.size() == 3) begin
            if (rx_bytes[2] == (rx_bytes[0] ^ rx_bytes[1])) begin
                exp_valid++;
                exp_move       = rx_bytes[1][3:0];
                exp_speed      = rx_bytes[1][7:4];
                last_exp_valid = start + LAT;
            end else begin
                exp_err++;
            end
            rx_bytes.delete();
        end
    endtask

    task automatic model_byte_err();
        exp_err++;
        rx_bytes.delete();
    endtask

    // Drives one 8N1 character starting at a falling clock edge; returns the start-bit cycle.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, output int start);
        uart_in = 1'b0;
        start   = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_in = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok, output int start);
        applyStimulus(b, stop_ok, start);
        if (stop_ok) model_byte(b, start);
        else model_byte_err();
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] p, input logic [7:0] c,
                              output int chk_start);
        int s;
        send_byte(h, 1'b1, s);
        send_byte(p, 1'b1, s);
        send_byte(c, 1'b1, chk_start);
    endtask

    task automatic idle_line(input int n);
        uart_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic glitch();
        uart_in = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        idle_line(2 * CPB);
    endtask

    task automatic check_state(input string tag);
        int el;
        #2;
        checkOutput({tag, "_valid_cnt"}, valid_seen, exp_valid);
        checkOutput({tag, "_err_cnt"}, err_seen, exp_err);
        el = cyc - last_exp_valid;
        if (WD_ON && el >= TMO - 2 && el <= TMO + 2) return;
        if (WD_ON && el > TMO) begin
            exp_move  = 4'b1000;
            exp_speed = 4'h0;
        end
        checkOutput({tag, "_move"}, move_cmd, exp_move);
        checkOutput({tag, "_speed"}, speed_level, exp_speed);
        checkOutput({tag, "_timeout"}, link_timeout, (WD_ON && el > TMO));
    endtask

    int         chk_start, s, lat, kind, gap;
    logic [7:0] p;

    initial begin
        $display("[TB] start, watchdog expected=%0d", WD_ON);
        rst_n   = 1'b0;
        uart_in = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle_line(10 * CPB);
        check_state("reset");

        send_frame(8'hA5, 8'h35, 8'h90, chk_start);
        idle_line(4);
        check_state("good1");
        checkOutput("good1_move_const", move_cmd, 4'b0101);
        checkOutput("good1_speed_const", speed_level, 4'b0011);
        lat = last_valid_cyc - chk_start;
        checkOutput($sformatf("latency_%0d_within1_of_%0d", lat, LAT),
                    (lat >= LAT - 1 && lat <= LAT + 1), 1);

        send_frame(8'hA5, 8'h35, 8'h91, chk_start);
        idle_line(4);
        check_state("bad_sum");
        checkOutput("bad_sum_move_const", move_cmd, 4'b0101);

        send_byte(8'hA5, 1'b1, s);
        send_byte(8'h35, 1'b0, s);
        idle_line(CPB);
        send_frame(8'hA5, 8'h01, 8'hA4, chk_start);
        idle_line(4);
        check_state("bad_stop");
        checkOutput("bad_stop_move_const", move_cmd, 4'b0001);

        send_byte(8'h00, 1'b1, s);
        send_byte(8'h12, 1'b1, s);
        glitch();
        send_frame(8'hA5, 8'h20, 8'h85, chk_start);
        idle_line(4);
        check_state("glitch");
        checkOutput("glitch_speed_const", speed_level, 4'b0010);

`ifdef CAR_CMD_RX_WATCHDOG_EN
        lt_rise_cyc = -1;
        idle_line(TMO + 60);
        checkOutput($sformatf("wd_rise_at_%0d_after_valid", lt_rise_cyc - last_valid_cyc),
                    ((lt_rise_cyc - last_valid_cyc) >= TMO - 1 &&
                     (lt_rise_cyc - last_valid_cyc) <= TMO + 1), 1);
        check_state("wd_expired");
        send_frame(8'hA5, 8'h47, 8'hA5 ^ 8'h47, chk_start);
        idle_line(4);
        check_state("wd_recover");
`endif

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            p    = 8'($urandom_range(0, 255));
            case (kind)
                0, 1, 2, 3, 4: send_frame(HDR, p, HDR ^ p, chk_start);
                5: send_frame(HDR, p, HDR ^ p ^ (8'h01 << $urandom_range(0, 7)), chk_start);
                6: send_byte(($urandom_range(0, 3) == 0) ? HDR : p, 1'b1, s);
                7: begin
                    send_byte(p, 1'b0, s);
                    idle_line(CPB);
                end
                default: glitch();
            endcase
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(300, 1100) : $urandom_range(1, 20);
            idle_line(gap);
            check_state($sformatf("rnd%0d", n));
        end

        checkOutput("valid_and_err_same_cycle", both_seen, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
